systolic_w_seq: RTL and testbench
=================================

SYSTOLIC_W_SEQ -- requirements
Module: systolic_w_seq

Interface
REQ-001 Parameter PE_ROW, default 8: number of PE rows, i.e. the maximum number of weight rows per load.
REQ-002 Parameter PE_COL, default 8: number of PE columns and the width of the column-enable mask.
REQ-003 Parameter BIT_ROW_ID, default 3: row-ID width, which SHALL satisfy 2^BIT_ROW_ID >= PE_ROW.
REQ-004 CLK  in  1  sole clock; all logic on posedge CLK.
REQ-005 RST  in  1  reset, synchronous, active-low.
REQ-006 i_Start  in  1  single-cycle load request.
REQ-007 i_Abort  in  1  cancels an in-flight load.
REQ-008 i_Row_Cnt  in  BIT_ROW_ID+1  rows to load; legal range 1..PE_ROW.
REQ-009 i_Col_Mask  in  PE_COL  columns to enable for every row of this load.
REQ-010 i_W_Valid  in  1  weight buffer holds the word for the current row.
REQ-011 o_W_Ready  out  1  sequencer accepts the current weight word.
REQ-012 o_Systolic_En_ID  out  BIT_ROW_ID  target row ID; feeds the weight loader stage.
REQ-013 o_Systolic_En_W  out  PE_COL  column write enables; feeds the weight loader stage.
REQ-014 o_Busy  out  1  high in every state except IDLE.
REQ-015 o_Done  out  1  one-cycle completion pulse.
REQ-016 o_Err  out  1  one-cycle pulse on a rejected start.

Function
REQ-017 The FSM SHALL have four states: IDLE, LOAD, DRAIN, DONE; all outputs SHALL be registered.
REQ-018 In IDLE, i_Start with i_Row_Cnt in 1..PE_ROW and i_Col_Mask != 0 SHALL latch the count and mask, clear the row counter, and enter LOAD.
REQ-019 In IDLE, i_Start with i_Row_Cnt == 0, i_Row_Cnt > PE_ROW, or i_Col_Mask == 0 SHALL pulse o_Err for one cycle and remain in IDLE.
REQ-020 i_Start SHALL be ignored outside IDLE and SHALL NOT alter the latched count or mask.
REQ-021 o_W_Ready SHALL be high exactly while in LOAD.
REQ-022 A handshake is i_W_Valid & o_W_Ready in the same cycle.
REQ-023 A handshake in cycle t SHALL drive o_Systolic_En_ID = current row and o_Systolic_En_W = latched mask in cycle t+1, then increment the row counter.
REQ-024 In any LOAD cycle without a handshake, the next cycle SHALL have o_Systolic_En_W = 0, with o_Systolic_En_ID holding its last value.
REQ-025 Gaps in i_W_Valid SHALL stall the row counter without skipping or repeating any row.
REQ-026 The handshake on row (count-1) SHALL leave LOAD: to DRAIN if the macro is defined, otherwise to DONE.
REQ-027 Rows SHALL be issued strictly 0,1,..,count-1, each exactly once; the row counter SHALL never exceed count-1 and SHALL never wrap.
REQ-028 DRAIN SHALL hold o_Systolic_En_W = 0 for PE_COL cycles, then go to DONE.
REQ-029 DONE SHALL assert o_Done for exactly one cycle, then return to IDLE.
REQ-030 i_Abort in LOAD or DRAIN SHALL return the FSM to IDLE on the next edge: o_Systolic_En_W = 0 next cycle, no o_Done, latched state cleared.
REQ-031 If i_Abort and a handshake occur in the same cycle, i_Abort SHALL win and that word SHALL NOT be issued.
REQ-032 i_Abort SHALL have no effect in IDLE or DONE.

Reset
REQ-033 With RST low at a posedge, the FSM SHALL go to IDLE and all outputs, the row counter, and the latched count and mask SHALL be 0.
REQ-034 Reset asserted mid-load SHALL abandon the load with no o_Done and no o_Err.
REQ-035 The first accepted i_Start SHALL be at the first edge after RST returns high.

Configuration
REQ-036 Macro SYSTOLIC_W_DRAIN_EN defined: the DRAIN state SHALL be present and o_Done SHALL follow the last handshake by PE_COL+1 cycles.
REQ-037 Macro SYSTOLIC_W_DRAIN_EN undefined: no DRAIN state SHALL exist and o_Done SHALL occur 1 cycle after the last handshake.

Verification
REQ-038 Reset, then Start with Row_Cnt=3 and Col_Mask=8'h0F, i_W_Valid held high -> En_ID 0,1,2 on consecutive cycles with En_W=8'h0F each, then o_Done once; without SYSTOLIC_W_DRAIN_EN o_Done occurs 1 cycle after the last handshake.
REQ-039 Row_Cnt=4 with i_W_Valid pattern 1,0,0,1,1,0,1 -> En_W nonzero only in the cycles following the valid cycles; En_ID sequence 0,1,2,3 with no duplicates.
REQ-040 Start with Row_Cnt=0, then Row_Cnt=9, then Col_Mask=0 -> three o_Err pulses; o_Busy stays 0 and En_W stays 0.
REQ-041 Abort asserted in the same cycle as the row-2 handshake of an 8-row load -> row 2 is never issued, En_W=0 next cycle, o_Busy falls, no o_Done; a subsequent Start loads normally.
REQ-042 RST low during the row-5 handshake of an 8-row load -> all outputs 0 next cycle; after release, Start with Row_Cnt=8 and mask 8'hFF issues rows 0..7; with SYSTOLIC_W_DRAIN_EN, o_Done occurs 9 cycles after the row-7 handshake.

Source files
------------

// File: rtl/systolic_w_seq.sv
// systolic_w_seq: weight-row load sequencer for a PE_ROW x PE_COL systolic array (optional drain via SYSTOLIC_W_DRAIN_EN)
module systolic_w_seq #(
  parameter int PE_ROW     = 8,
  parameter int PE_COL     = 8,
  parameter int BIT_ROW_ID = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_Start,
  input  logic                  i_Abort,
  input  logic [BIT_ROW_ID:0]   i_Row_Cnt,
  input  logic [PE_COL-1:0]     i_Col_Mask,
  input  logic                  i_W_Valid,
  output logic                  o_W_Ready,
  output logic [BIT_ROW_ID-1:0] o_Systolic_En_ID,
  output logic [PE_COL-1:0]     o_Systolic_En_W,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Err
);
`ifdef SYSTOLIC_W_DRAIN_EN
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  localparam int DW = $clog2(PE_COL + 1);
  logic [DW-1:0] drain_q, drain_d;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif
  state_t                state_q, state_d;
  logic [BIT_ROW_ID:0]   cnt_q, cnt_d;
  logic [PE_COL-1:0]     mask_q, mask_d;
  logic [BIT_ROW_ID-1:0] row_q, row_d;
  logic [BIT_ROW_ID-1:0] en_id_q, en_id_d;
  logic [PE_COL-1:0]     en_w_q, en_w_d;
  logic                  ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                  hs, start_ok, last_row;
  assign hs       = i_W_Valid & ready_q;
  assign start_ok = (i_Row_Cnt != '0) && (i_Row_Cnt <= (BIT_ROW_ID+1)'(PE_ROW)) && (i_Col_Mask != '0);
  assign last_row = {1'b0, row_q} == cnt_q - 1'b1;
  // next-state: latches load parameters, walks rows on handshakes, abort wins over a same-cycle handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    row_d   = row_q;
    en_id_d = en_id_q;
    en_w_d  = '0;
    err_d   = 1'b0;
`ifdef SYSTOLIC_W_DRAIN_EN
    drain_d = drain_q;
`endif
    case (state_q)
      IDLE: if (i_Start) begin
        if (start_ok) begin
          state_d = LOAD;
          cnt_d   = i_Row_Cnt;
          mask_d  = i_Col_Mask;
          row_d   = '0;
        end else err_d = 1'b1;
      end
      LOAD: if (i_Abort) begin
        state_d = IDLE;
        cnt_d   = '0;
        mask_d  = '0;
        row_d   = '0;
      end else if (hs) begin
        en_id_d = row_q;
        en_w_d  = mask_q;
        if (last_row) begin
`ifdef SYSTOLIC_W_DRAIN_EN
          state_d = DRAIN;
          drain_d = '0;
`else
          state_d = DONE;
`endif
        end else row_d = row_q + 1'b1;
      end
`ifdef SYSTOLIC_W_DRAIN_EN
      DRAIN: if (i_Abort) begin
        state_d = IDLE;
        cnt_d   = '0;
        mask_d  = '0;
        row_d   = '0;
      end else if (drain_q == DW'(PE_COL - 1)) state_d = DONE;
      else drain_d = drain_q + 1'b1;
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        mask_d  = '0;
        row_d   = '0;
      end
    endcase
    ready_d = state_d == LOAD;
    busy_d  = state_d != IDLE;
    done_d  = state_d == DONE;
  end
  // state and registered outputs, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      row_q   <= '0;
      en_id_q <= '0;
      en_w_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SYSTOLIC_W_DRAIN_EN
      drain_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      row_q   <= row_d;
      en_id_q <= en_id_d;
      en_w_q  <= en_w_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SYSTOLIC_W_DRAIN_EN
      drain_q <= drain_d;
`endif
    end
  end
  assign o_W_Ready        = ready_q;
  assign o_Systolic_En_ID = en_id_q;
  assign o_Systolic_En_W  = en_w_q;
  assign o_Busy           = busy_q;
  assign o_Done           = done_q;
  assign o_Err            = err_q;
endmodule

// File: tb/tb_systolic_w_seq.sv
// tb_systolic_w_seq: vector table plus scoreboard bench for systolic_w_seq
module tb_systolic_w_seq;
`ifdef SYSTOLIC_W_DRAIN_EN
  localparam int EXP_LAT = 8;
`else
  localparam int EXP_LAT = 0;
`endif
  logic       CLK, RST, i_Start, i_Abort, i_W_Valid;
  logic [3:0] i_Row_Cnt;
  logic [7:0] i_Col_Mask;
  logic       o_W_Ready, o_Busy, o_Done, o_Err;
  logic [2:0] o_Systolic_En_ID;
  logic [7:0] o_Systolic_En_W;
  systolic_w_seq dut (
    .CLK(CLK), .RST(RST), .i_Start(i_Start), .i_Abort(i_Abort),
    .i_Row_Cnt(i_Row_Cnt), .i_Col_Mask(i_Col_Mask), .i_W_Valid(i_W_Valid),
    .o_W_Ready(o_W_Ready), .o_Systolic_En_ID(o_Systolic_En_ID),
    .o_Systolic_En_W(o_Systolic_En_W), .o_Busy(o_Busy), .o_Done(o_Done), .o_Err(o_Err)
  );
  typedef struct {
    logic [3:0]  cnt;
    logic [7:0]  mask;
    logic [15:0] vpat;
    logic        err;
  } vec_t;
  typedef struct packed {
    logic [2:0] id;
    logic [7:0] w;
  } exp_t;
  vec_t vecs[8];
  exp_t sb[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0;
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    cyc++;
    if (o_Done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (o_Err) err_cnt++;
    if (o_Systolic_En_W != 0) begin
      if (sb.size() == 0) chk("unexpected_en_w", 32'(o_Systolic_En_W), 0);
      else begin
        e = sb.pop_front();
        chk("en_id", 32'(o_Systolic_En_ID), 32'(e.id));
        chk("en_w", 32'(o_Systolic_En_W), 32'(e.w));
      end
    end
  endtask
  task automatic finish_load(input int d0, input int hs);
    int w = 0;
    while (done_cnt == d0 && w < 40) begin
      tick();
      w++;
    end
    chk("done_latency", done_cnt != d0 ? 32'(done_cyc - hs) : 32'd999, EXP_LAT);
    tick();
    chk("done_pulse_width", 32'(o_Done), 0);
    chk("busy_after_done", 32'(o_Busy), 0);
    chk("sb_empty", 32'(sb.size()), 0);
    chk("done_once", 32'(done_cnt - d0), 1);
  endtask
  task automatic run_load(input logic [3:0] cnt, input logic [7:0] mask, input logic [15:0] vpat);
    int row = 0, k = 0, d0;
    logic v;
    logic [2:0] r3;
    i_Start = 1'b1; i_Row_Cnt = cnt; i_Col_Mask = mask; i_W_Valid = 1'b0;
    tick();
    i_Start = 1'b0;
    chk("ready_in_load", 32'(o_W_Ready), 1);
    chk("busy_in_load", 32'(o_Busy), 1);
    d0 = done_cnt;
    while (row < int'(cnt) && k < 64) begin
      v = (k < 16) ? vpat[k] : 1'b1;
      i_W_Valid = v;
      if (v) begin
        r3 = 3'(row);
        sb.push_back({r3, mask});
        row++;
      end
      tick();
      k++;
    end
    i_W_Valid = 1'b0;
    chk("ready_after_load", 32'(o_W_Ready), 0);
    finish_load(d0, cyc);
  endtask
  task automatic run_err(input logic [3:0] cnt, input logic [7:0] mask);
    int e0 = err_cnt;
    i_Start = 1'b1; i_Row_Cnt = cnt; i_Col_Mask = mask;
    tick();
    i_Start = 1'b0;
    chk("err_pulse", 32'(o_Err), 1);
    chk("err_busy", 32'(o_Busy), 0);
    chk("err_en_w", 32'(o_Systolic_En_W), 0);
    chk("err_ready", 32'(o_W_Ready), 0);
    tick();
    chk("err_width", 32'(o_Err), 0);
    chk("err_count", 32'(err_cnt - e0), 1);
  endtask
  initial begin
    int d0;
    vecs[0] = '{4'd3, 8'h0F, 16'hFFFF, 1'b0};
    vecs[1] = '{4'd4, 8'hA5, 16'h0059, 1'b0};
    vecs[2] = '{4'd0, 8'h0F, 16'hFFFF, 1'b1};
    vecs[3] = '{4'd9, 8'h0F, 16'hFFFF, 1'b1};
    vecs[4] = '{4'd3, 8'h00, 16'hFFFF, 1'b1};
    vecs[5] = '{4'd8, 8'hFF, 16'hFFFF, 1'b0};
    vecs[6] = '{4'd1, 8'h80, 16'hFFFF, 1'b0};
    vecs[7] = '{4'd5, 8'h3C, 16'h5555, 1'b0};
    RST = 1'b0; i_Start = 1'b0; i_Abort = 1'b0; i_W_Valid = 1'b0; i_Row_Cnt = '0; i_Col_Mask = '0;
    tick();
    tick();
    chk("rst_busy", 32'(o_Busy), 0);
    chk("rst_ready", 32'(o_W_Ready), 0);
    chk("rst_done", 32'(o_Done), 0);
    chk("rst_err", 32'(o_Err), 0);
    chk("rst_en_id", 32'(o_Systolic_En_ID), 0);
    chk("rst_en_w", 32'(o_Systolic_En_W), 0);
    RST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].err) run_err(vecs[i].cnt, vecs[i].mask);
      else run_load(vecs[i].cnt, vecs[i].mask, vecs[i].vpat);
    end
    i_Abort = 1'b1;
    tick();
    i_Abort = 1'b0;
    chk("abort_idle_busy", 32'(o_Busy), 0);
    i_Start = 1'b1; i_Row_Cnt = 4'd3; i_Col_Mask = 8'h0F;
    tick();
    d0 = done_cnt;
    i_Row_Cnt = 4'd1; i_Col_Mask = 8'hF0; i_W_Valid = 1'b1;
    sb.push_back({3'd0, 8'h0F});
    tick();
    i_Start = 1'b0;
    sb.push_back({3'd1, 8'h0F});
    tick();
    sb.push_back({3'd2, 8'h0F});
    tick();
    i_W_Valid = 1'b0;
    finish_load(d0, cyc);
    i_Start = 1'b1; i_Row_Cnt = 4'd8; i_Col_Mask = 8'hFF;
    tick();
    i_Start = 1'b0;
    d0 = done_cnt;
    i_W_Valid = 1'b1;
    sb.push_back({3'd0, 8'hFF});
    tick();
    sb.push_back({3'd1, 8'hFF});
    tick();
    i_Abort = 1'b1;
    tick();
    i_Abort = 1'b0; i_W_Valid = 1'b0;
    chk("abort_en_w", 32'(o_Systolic_En_W), 0);
    chk("abort_busy", 32'(o_Busy), 0);
    chk("abort_ready", 32'(o_W_Ready), 0);
    for (int i = 0; i < 12; i++) tick();
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    chk("abort_sb_empty", 32'(sb.size()), 0);
    run_load(4'd2, 8'h33, 16'hFFFF);
    i_Start = 1'b1; i_Row_Cnt = 4'd8; i_Col_Mask = 8'hFF;
    tick();
    i_Start = 1'b0;
    d0 = done_cnt;
    i_W_Valid = 1'b1;
    for (int r = 0; r < 5; r++) begin
      sb.push_back({3'(r), 8'hFF});
      tick();
    end
    RST = 1'b0;
    tick();
    i_W_Valid = 1'b0;
    chk("midrst_en_w", 32'(o_Systolic_En_W), 0);
    chk("midrst_en_id", 32'(o_Systolic_En_ID), 0);
    chk("midrst_busy", 32'(o_Busy), 0);
    chk("midrst_ready", 32'(o_W_Ready), 0);
    chk("midrst_done_err", 32'({o_Done, o_Err}), 0);
    chk("midrst_sb_empty", 32'(sb.size()), 0);
    chk("midrst_no_done", 32'(done_cnt - d0), 0);
    RST = 1'b1;
    run_load(4'd8, 8'hFF, 16'hFFFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
